mult_seq_handshake: RTL and testbench

//  Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, retiring RADIX

---
 rtl/mult_seq_handshake.sv | 118 +++++++++++
 tb/tb_mult_seq_handshake.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_handshake.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Retires RADIX multiplier bits per BUSY cycle; signed mode multiplies magnitudes and fixes the sign at the end.
module mult_seq_handshake #(
    parameter int WIDTH = 32,
    parameter int RADIX = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [1:0]         dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and operands/product are only meaningful while valid.

    localparam int N  = WIDTH / RADIX;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;
    logic               sign;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitudes as unsigned WIDTH-bit values; the most negative operand maps onto itself.
    always_comb begin
        a_neg = in_signed & in_a[WIDTH-1];
        b_neg = in_signed & in_b[WIDTH-1];
        a_mag = a_neg ? (~in_a + 1'b1) : in_a;
        b_mag = b_neg ? (~in_b + 1'b1) : in_b;
    end

    // Partial product of the shifted multiplicand and the low RADIX multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < RADIX; i++) begin
            if (b_sh[i]) partial = partial + (a_sh << i);
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{WIDTH{1'b0}}, a_mag};
                        b_sh     <= b_mag;
                        acc      <= '0;
                        cnt      <= '0;
                        sign     <= a_neg ^ b_neg;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // N accumulate cycles, then one cycle to apply the sign and publish.
                    if (cnt == LAST) begin
                        out_p     <= sign ? (~acc + 1'b1) : acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc  <= acc + partial;
                        a_sh <= a_sh << RADIX;
                        b_sh <= b_sh >> RADIX;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_handshake.sv
// Bench for mult_seq_handshake: directed and random products on a 32x32/radix-1 and a 16x16/radix-4 instance.
// Expected products come from plain integer multiplication and are matched against outputs in order.
module tb_mult_seq_handshake;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit, radix-1 instance
    logic        clr32, v32, rdy32, s32, ov32, or32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic [1:0]  st32;
    // 16-bit, radix-4 instance
    logic        clr16, v16, rdy16, s16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic [1:0]  st16;

    mult_seq_handshake #(.WIDTH(32), .RADIX(1)) u32 (
        .clk(clk), .rst_n(rst_n), .clr(clr32), .in_valid(v32), .in_ready(rdy32),
        .in_signed(s32), .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(or32),
        .out_p(p32), .dbg_state(st32)
    );
    mult_seq_handshake #(.WIDTH(16), .RADIX(4)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr16), .in_valid(v16), .in_ready(rdy16),
        .in_signed(s16), .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(or16),
        .out_p(p16), .dbg_state(st16)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp32_q[$];
    logic [31:0] exp16_q[$];
    int acc32 = 0, done32 = 0, done16 = 0;
    logic [63:0] last32 = '0;
    logic rand_bp = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int sa, sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        return {16'b0, a} * {16'b0, b};
    endfunction

    // Scoreboard: accepts push the model result, output transfers pop and compare.
    always @(negedge clk) begin
        if (rst_n && !clr32 && v32 && rdy32) begin
            exp32_q.push_back(ref32(a32, b32, s32));
            acc32++;
        end
        if (rst_n && !clr16 && v16 && rdy16) exp16_q.push_back(ref16(a16, b16, s16));
        if (rst_n && !clr32 && ov32 && or32) begin
            if (exp32_q.size() == 0) check("p32_unexpected", {64'b0, p32}, 128'h1_0000_0000_0000_0000);
            else begin
                last32 = exp32_q.pop_front();
                check("p32", p32, last32);
            end
            done32++;
        end
        if (rst_n && !clr16 && ov16 && or16) begin
            if (exp16_q.size() == 0) check("p16_unexpected", {96'b0, p16}, 128'h1_0000_0000);
            else check("p16", p16, exp16_q.pop_front());
            done16++;
        end
    end

    // Random back-pressure on the 16-bit instance during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) or16 = ($urandom_range(0, 3) != 0);
        end
    end

    // Drivers: called at posedge+1, return at accept edge+1.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        a32 = a; b32 = b; s32 = s; v32 = 1'b1;
        @(negedge clk);
        while (!rdy32 && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("issue32_timeout", 0, 1);
        @(posedge clk);
        #1 v32 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        a16 = a; b16 = b; s16 = s; v16 = 1'b1;
        @(negedge clk);
        while (!rdy16 && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("issue16_timeout", 0, 1);
        @(posedge clk);
        #1 v16 = 1'b0;
    endtask

    task automatic wait_valid32(output int n);
        n = 0;
        while (!ov32 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ov32) check("wait_valid32_timeout", 0, 1);
    endtask

    task automatic wait_valid16(output int n);
        n = 0;
        while (!ov16 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ov16) check("wait_valid16_timeout", 0, 1);
    endtask

    // Full operation on the 32-bit instance with out_ready high; returns cycles to out_valid.
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
        issue32(a, b, s);
        wait_valid32(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, a0, d0;
        logic [63:0] hold;
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        clr32 = 0; v32 = 0; s32 = 0; a32 = '0; b32 = '0; or32 = 1;
        clr16 = 0; v16 = 0; s16 = 0; a16 = '0; b16 = '0; or16 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", rdy32, 1);
        check("reset_out_valid", ov32, 0);
        check("reset_out_p", p32, 0);
        check("reset_state", st32, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
        check("t1_latency", n, 33);
        check("t1_product", p32, 64'hFFFF_FFFE_0000_0001);
        run32(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, n);
        check("t2_neg3x5", p32, 64'hFFFF_FFFF_FFFF_FFF1);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, n);
        check("t2_minsq", p32, 64'h4000_0000_0000_0000);
        run32(32'h0000_0000, 32'h1234_5678, 1'b0, n);
        check("t6_zero", p32, 64'h0);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n);
        check("t6_m1xm1", p32, 64'h1);
        check("t6_signed_latency", n, 33);
        repeat (4) @(posedge clk);
        #1 check("idle_hold_p", p32, 64'h1);

        // Back-pressure in DONE
        or32 = 1'b0;
        issue32($urandom, $urandom, 1'b1);
        hold = ref32(a32, b32, 1'b1);
        a32 = $urandom; b32 = $urandom; s32 = 1'b0;
        wait_valid32(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", ov32, 1);
            check("bp_out_p", p32, hold);
            check("bp_in_ready", rdy32, 0);
        end
        or32 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", rdy32, 1);
        check("bp_release_out_valid", ov32, 0);

        // Asynchronous reset during BUSY
        issue32(32'd1234, 32'd5678, 1'b0);
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        void'(exp32_q.pop_back());
        #1;
        check("rst_abort_out_valid", ov32, 0);
        check("rst_abort_in_ready", rdy32, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Synchronous clear during BUSY
        run32(32'd7, 32'd6, 1'b0, n);
        check("t4_7x6", p32, 64'd42);
        issue32(32'd99, 32'd77, 1'b0);
        repeat (12) @(posedge clk);
        #1 clr32 = 1'b1;
        check("clr_not_async", rdy32, 0);
        @(posedge clk);
        #1 clr32 = 1'b0;
        void'(exp32_q.pop_back());
        check("clr_out_valid", ov32, 0);
        check("clr_in_ready", rdy32, 1);
        check("clr_keeps_p", p32, last32);
        repeat (40) @(posedge clk);
        #1 check("clr_no_late_output", done32, 7);
        run32(32'd7, 32'd6, 1'b0, n);
        check("clr_next_7x6", p32, 64'd42);

        // clr wins over in_valid in IDLE
        a32 = 32'd3; b32 = 32'd3; s32 = 1'b0; clr32 = 1'b1; v32 = 1'b1;
        @(posedge clk);
        #1 clr32 = 1'b0; v32 = 1'b0;
        check("clr_blocks_accept_ready", rdy32, 1);
        check("clr_blocks_accept_state", st32, 0);

        // in_valid held high: one accept per completed op
        a0 = acc32; d0 = done32;
        a32 = 32'd3; b32 = 32'd4; s32 = 1'b0; v32 = 1'b1;
        repeat (120) @(posedge clk);
        #1 v32 = 1'b0;
        n = 0;
        while ((done32 - d0) != (acc32 - a0) && n < 100) begin @(posedge clk); #1; n++; end
        check("held_accepts_eq_done", acc32 - a0, done32 - d0);
        check("held_accepts_min", (acc32 - a0) >= 3, 1);

        // A few random ops on the 32-bit instance
        for (int i = 0; i < 40; i++) run32($urandom, $urandom, 1'($urandom_range(0, 1)), n);

        // 16-bit radix-4 instance
        issue16(16'hABCD, 16'h1234, 1'b0);
        wait_valid16(n);
        check("r4_latency", n, 5);
        check("r4_product", p16, 32'h0C37_4FA4);
        @(posedge clk);
        #1 rand_bp = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) ra = 16'h8000;
            if (i % 70 == 0) rb = 16'hFFFF;
            issue16(ra, rb, 1'($urandom_range(0, 1)));
        end
        n = 0;
        while (exp16_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        rand_bp = 1'b0;
        or16 = 1'b1;
        check("r4_drained", exp16_q.size(), 0);
        check("r4_done_count", done16, 1001);
        check("r32_drained", exp32_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
